force_output_node_router: RTL
=============================

Name: force_output_node_router

Overview:
- Return-path ring node for partial neighbour forces; one instance per cell, ring order opposite to the position ring.
- Each cycle it takes at most one force packet from the upstream ring node and at most one from its local PE's force FIFO.
- Packets whose destination GCID equals this node's cell are delivered to the local force cache accumulator; all others are forwarded downstream.
- The ring has priority. A local packet enters only when the outgoing ring slot is free.

Parameters:
- FIFO_DEPTH, 16, depth of the local PE force FIFO (power of 2).
- FIFO_AF_LEVEL, 12, occupancy at or above which o_pe_back_pressure is asserted.
- MAX_LIFETIME, NUM_DEST_CELLS-1, hop budget loaded when a local packet is injected.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_local_gcid  in  3*GLOBAL_CELL_ID_WIDTH  this node's cell id (static)
- i_ring_force_pkt  in  FORCE_PKT_STRUCT_WIDTH  packet from upstream node
- i_ring_gcid  in  3*GLOBAL_CELL_ID_WIDTH  destination cell of ring packet
- i_ring_lifetime  in  NB_CELL_COUNT_WIDTH  remaining hops; 0 means empty slot
- i_pe_force_pkt  in  FORCE_PKT_STRUCT_WIDTH  force from local PE
- i_pe_gcid  in  3*GLOBAL_CELL_ID_WIDTH  destination cell of PE force
- i_pe_force_valid  in  1  PE write strobe
- o_pe_back_pressure  out  1  FIFO occupancy >= FIFO_AF_LEVEL
- o_force_pkt_to_ring  out  force_packet_t  to downstream node
- o_gcid_to_ring  out  3*GLOBAL_CELL_ID_WIDTH
- o_lifetime_to_ring  out  NB_CELL_COUNT_WIDTH  0 means slot empty
- o_force_pkt_to_cache  out  force_packet_t  delivery to local force cache
- o_force_pkt_to_cache_valid  out  1
- o_route_error  out  1  one-cycle pulse when an expired packet is dropped

Behaviour:
- All outputs are registered; latency is 1 cycle from input to output.
- Reset (async, rst=1): every output and the FIFO pointers/count clear to 0. Any packet in the FIFO or on the ring input is discarded, including mid-operation.
- Ring slot decode, evaluated when i_ring_lifetime > 0:
  - i_ring_gcid == i_local_gcid: deliver to the cache (valid=1). The outgoing slot is free.
  - Otherwise, if i_ring_lifetime > 1: forward the packet and gcid unchanged, with lifetime-1.
  - Otherwise (lifetime == 1, no match): drop the packet, pulse o_route_error, slot free.
- FIFO head handling:
  - Pop only when the head can be placed this cycle.
  - Head gcid != local: inject to the ring with lifetime MAX_LIFETIME, only if the outgoing slot is free.
  - Head gcid == local (self-force): deliver directly to the cache, only if the ring did not deliver to the cache this cycle. Otherwise it stalls.
- A ring delivery to the cache and a local injection to the ring may occur in the same cycle.
- When the outgoing slot is unused, drive o_lifetime_to_ring=0 and hold the packet/gcid registers.
- o_force_pkt_to_cache_valid=0 when nothing is delivered; packet data hold.
- FIFO push happens when i_pe_force_valid=1 and the FIFO is not full.
- Push to a full FIFO is a PE protocol violation: the write is dropped and the count is unchanged.
- Simultaneous push and pop on a full FIFO is allowed, and the count stays the same.
- o_pe_back_pressure is combinational from the registered count.
- All width arithmetic is unsigned. The lifetime decrement never underflows, because lifetime == 1 takes the drop path.

Decomposition:
- MD_pkg gains:
  - force_packet_t {particle_id, fz, fy, fx}, each force component DATA_WIDTH.
  - FORCE_PKT_STRUCT_WIDTH.
- NUM_DEST_CELLS, GLOBAL_CELL_ID_WIDTH and NB_CELL_COUNT_WIDTH are reused from MD_pkg.
- One sub-module, force_pkt_fifo: synchronous FIFO, first-word-fall-through, with a count output and async active-high reset. It is generic over width and depth.

Test Plan:
- Ring packet with gcid=local, lifetime=5, FIFO empty -> next cycle cache_valid=1 with the same packet, o_lifetime_to_ring=0.
- Ring packet with gcid!=local, lifetime=5 -> next cycle ring out has the same packet and gcid, lifetime=4, cache_valid=0.
- Ring packet with gcid!=local, lifetime=1 -> o_route_error=1 for one cycle, ring lifetime out 0, cache_valid=0.
- Ring traffic continuous and non-local for 20 cycles, PE pushes 14 packets -> no injection occurs, back_pressure=1 once count reaches 12. After ring idles, one injection per cycle with lifetime=NUM_DEST_CELLS-1, and the FIFO drains in 14 cycles.
- Ring packet to local cache and FIFO head non-local in the same cycle -> cache_valid=1 and ring out carries the FIFO head with lifetime MAX_LIFETIME, both on the next cycle. With the FIFO head local instead, the head stalls 1 cycle and is delivered the following cycle.
- rst pulsed mid-stream with 6 packets in the FIFO and ring valid -> all outputs 0 immediately (asynchronous), count=0, back_pressure=0. Nothing emerges after release until new stimulus.

Source files
------------

// File: rtl/MD_pkg.sv
// Shared MD datapath definitions: cell-id, hop-count and force packet
// layout used by the force return ring.
package MD_pkg;

  localparam int DATA_WIDTH           = 16;
  localparam int PARTICLE_ID_WIDTH    = 8;
  localparam int GLOBAL_CELL_ID_WIDTH = 3;
  localparam int NUM_DEST_CELLS       = 14;
  localparam int NB_CELL_COUNT_WIDTH  = 4;

  // Full destination cell id is {x, y, z}.
  localparam int GCID_W = 3 * GLOBAL_CELL_ID_WIDTH;

  typedef struct packed {
    logic        [PARTICLE_ID_WIDTH-1:0] particle_id;
    logic signed [DATA_WIDTH-1:0]        fz;
    logic signed [DATA_WIDTH-1:0]        fy;
    logic signed [DATA_WIDTH-1:0]        fx;
  } force_packet_t;

  localparam int FORCE_PKT_STRUCT_WIDTH = $bits(force_packet_t);

  function automatic logic gcid_eq(input logic [GCID_W-1:0] a,
                                   input logic [GCID_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/force_pkt_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (pointers/count only)
//   wr_en     write strobe; dropped when full unless a read happens too
//   wr_data   write data
//   rd_en     pop the head (ignored when empty)
//   rd_data   current head, valid whenever empty=0
//   empty     no entries
//   full      DEPTH entries
//   count     occupancy, 0..DEPTH
module force_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = rd_en && !empty;
  // A full FIFO still accepts a write in the cycle its head leaves.
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/force_output_node_router.sv
// Return-path ring node for partial neighbour forces. Ring packets addressed
// to this cell go to the local force cache, others are forwarded with one hop
// consumed; an expired packet is dropped with a route-error pulse. Local PE
// forces queue in a FIFO and enter the ring only through a free slot, or go
// straight to the cache when addressed to this cell.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_local_gcid                this node's cell id (static)
//   i_ring_force_pkt/gcid/lifetime  upstream slot (lifetime 0 = empty)
//   i_pe_force_pkt/gcid/valid   local PE force write
//   o_pe_back_pressure          FIFO occupancy >= FIFO_AF_LEVEL
//   o_force_pkt_to_ring, o_gcid_to_ring, o_lifetime_to_ring  downstream slot
//   o_force_pkt_to_cache, o_force_pkt_to_cache_valid         cache delivery
//   o_route_error               one-cycle pulse on expired-packet drop
module force_output_node_router
  import MD_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int FIFO_AF_LEVEL = 12,
  parameter int MAX_LIFETIME  = NUM_DEST_CELLS - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [GCID_W-1:0]                 i_local_gcid,
  input  logic [FORCE_PKT_STRUCT_WIDTH-1:0] i_ring_force_pkt,
  input  logic [GCID_W-1:0]                 i_ring_gcid,
  input  logic [NB_CELL_COUNT_WIDTH-1:0]    i_ring_lifetime,
  input  logic [FORCE_PKT_STRUCT_WIDTH-1:0] i_pe_force_pkt,
  input  logic [GCID_W-1:0]                 i_pe_gcid,
  input  logic                              i_pe_force_valid,
  output logic                              o_pe_back_pressure,
  output force_packet_t                     o_force_pkt_to_ring,
  output logic [GCID_W-1:0]                 o_gcid_to_ring,
  output logic [NB_CELL_COUNT_WIDTH-1:0]    o_lifetime_to_ring,
  output force_packet_t                     o_force_pkt_to_cache,
  output logic                              o_force_pkt_to_cache_valid,
  output logic                              o_route_error
);

  localparam int PKT_W  = FORCE_PKT_STRUCT_WIDTH;
  localparam int ENT_W  = GCID_W + PKT_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int LT_W   = NB_CELL_COUNT_WIDTH;

  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(FIFO_AF_LEVEL);
  localparam logic [LT_W-1:0]  MAX_LT   = LT_W'(MAX_LIFETIME);
  localparam logic [LT_W-1:0]  LT_ONE   = LT_W'(1);

  logic [ENT_W-1:0]  fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;

  logic [GCID_W-1:0] head_gcid;
  logic [PKT_W-1:0]  head_pkt;
  logic              ring_vld_p0;
  logic              ring_match_p0;
  logic              ring_fwd_p0;
  logic              ring_drop_p0;
  logic              inject_p0;
  logic              self_dlv_p0;

  force_pkt_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (i_pe_force_valid),
    .wr_data ({i_pe_gcid, i_pe_force_pkt}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign o_pe_back_pressure = (fifo_count >= AF_LEVEL);

  // Stage p0: slot decode and FIFO head arbitration
  assign head_gcid     = fifo_rdata[PKT_W +: GCID_W];
  assign head_pkt      = fifo_rdata[PKT_W-1:0];
  assign ring_vld_p0   = (i_ring_lifetime != '0);
  assign ring_match_p0 = ring_vld_p0 && gcid_eq(i_ring_gcid, i_local_gcid);
  assign ring_fwd_p0   = ring_vld_p0 && !ring_match_p0 && (i_ring_lifetime > LT_ONE);
  assign ring_drop_p0  = ring_vld_p0 && !ring_match_p0 && (i_ring_lifetime == LT_ONE);
  // Ring traffic owns the outgoing slot; the cache port is shared with ring
  // deliveries, which also win.
  assign inject_p0     = !fifo_empty && !gcid_eq(head_gcid, i_local_gcid) && !ring_fwd_p0;
  assign self_dlv_p0   = !fifo_empty &&  gcid_eq(head_gcid, i_local_gcid) && !ring_match_p0;
  assign fifo_pop      = inject_p0 || self_dlv_p0;

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_force_pkt_to_ring        <= '0;
      o_gcid_to_ring             <= '0;
      o_lifetime_to_ring         <= '0;
      o_force_pkt_to_cache       <= '0;
      o_force_pkt_to_cache_valid <= 1'b0;
      o_route_error              <= 1'b0;
    end else begin
      if (ring_fwd_p0) begin
        o_force_pkt_to_ring <= force_packet_t'(i_ring_force_pkt);
        o_gcid_to_ring      <= i_ring_gcid;
        o_lifetime_to_ring  <= i_ring_lifetime - LT_ONE;
      end else if (inject_p0) begin
        o_force_pkt_to_ring <= force_packet_t'(head_pkt);
        o_gcid_to_ring      <= head_gcid;
        o_lifetime_to_ring  <= MAX_LT;
      end else begin
        o_lifetime_to_ring  <= '0;
      end

      if (ring_match_p0) begin
        o_force_pkt_to_cache       <= force_packet_t'(i_ring_force_pkt);
        o_force_pkt_to_cache_valid <= 1'b1;
      end else if (self_dlv_p0) begin
        o_force_pkt_to_cache       <= force_packet_t'(head_pkt);
        o_force_pkt_to_cache_valid <= 1'b1;
      end else begin
        o_force_pkt_to_cache_valid <= 1'b0;
      end

      o_route_error <= ring_drop_p0;
    end
  end

endmodule
